// File: rtl/butterfly_credit_scheduler.sv
// Credit-based admission scheduler with per-destination round-robin arbitration for the butterfly network.
// Optional macro BFLY_CREDIT_CHECK_EN adds err_sticky (credit over-return / grant-outside-RUN detection).

module bcs_dst_arb #(
    parameter int LOG2 = 3,
    parameter int N    = 8
) (
    input  logic [N-1:0]    req,
    input  logic [LOG2-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt
);
    logic [LOG2-1:0] idx;
    logic            found;

    // Scan upward from ptr; the LOG2-bit add wraps mod N.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + LOG2'(k);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

module butterfly_credit_scheduler #(
    parameter int  NETWORK_WIDTH_LOG2 = 3,
    parameter int  W                  = 8,
    parameter int  CREDIT_DEPTH       = 4,
    localparam int N                  = 2**NETWORK_WIDTH_LOG2,
    localparam int L                  = NETWORK_WIDTH_LOG2,
    localparam int IW                 = $clog2(N*CREDIT_DEPTH+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_enable,
    input  logic [N-1:0]    up_valid_vec,
    input  logic [L*N-1:0]  up_dst_vec,
    input  logic [W*N-1:0]  up_payload_vec,
    output logic [N-1:0]    up_ready_vec,
    output logic [N-1:0]    net_valid_vec,
    output logic [L*N-1:0]  net_dst_vec,
    output logic [W*N-1:0]  net_payload_vec,
    input  logic [N-1:0]    net_ready_vec,
    input  logic [N-1:0]    ret_fire_vec,
    output logic            busy,
    output logic            drained,
    output logic [IW-1:0]   inflight_total
`ifdef BFLY_CREDIT_CHECK_EN
    ,
    output logic            err_sticky
`endif
);
    localparam int CW = $clog2(CREDIT_DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [N-1:0][CW-1:0]   credit, credit_nxt;
    logic [L-1:0]           rr_ptr;
    logic [N-1:0][N-1:0]    dst_req, dst_gnt;   // [dst][lane]
    logic [N-1:0]           grant, fire, take;
    logic                   all_full, run_en, drained_set;
    logic [IW-1:0]          credit_sum;

    always_comb begin
        dst_req = '0;
        for (int d = 0; d < N; d++)
            for (int i = 0; i < N; i++)
                dst_req[d][i] = up_valid_vec[i] && (up_dst_vec[i*L +: L] == L'(d));
    end

    for (genvar d = 0; d < N; d++) begin : g_arb
        bcs_dst_arb #(.LOG2(L), .N(N)) u_arb (
            .req (dst_req[d]),
            .ptr (rr_ptr),
            .en  (run_en && (credit[d] != '0)),
            .gnt (dst_gnt[d])
        );
    end

    // Each lane carries one destination, so per-destination grants are disjoint.
    always_comb begin
        grant = '0;
        for (int d = 0; d < N; d++)
            grant = grant | dst_gnt[d];
    end

    assign net_valid_vec   = up_valid_vec & grant;
    assign up_ready_vec    = grant & net_ready_vec;
    assign fire            = net_valid_vec & net_ready_vec;
    assign net_dst_vec     = up_dst_vec;
    assign net_payload_vec = up_payload_vec;

    always_comb begin
        take = '0;
        for (int d = 0; d < N; d++)
            take[d] = |(dst_gnt[d] & fire);
    end

`ifdef BFLY_CREDIT_CHECK_EN
    logic over_ret;
`endif

    always_comb begin
        credit_nxt = credit;
`ifdef BFLY_CREDIT_CHECK_EN
        over_ret = 1'b0;
`endif
        for (int d = 0; d < N; d++) begin
            credit_nxt[d] = credit[d] - CW'(take[d]) + CW'(ret_fire_vec[d]);
`ifdef BFLY_CREDIT_CHECK_EN
            if (ret_fire_vec[d] && !take[d] && (credit[d] == FULL)) begin
                credit_nxt[d] = FULL;
                over_ret      = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        all_full   = 1'b1;
        credit_sum = '0;
        for (int d = 0; d < N; d++) begin
            all_full   = all_full && (credit[d] == FULL);
            credit_sum = credit_sum + IW'(credit[d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Re-enable during drain wins over completion, so no drained pulse in that case.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_enable) state_nxt = RUN;
            RUN:     if (!cfg_enable) state_nxt = DRAIN;
            DRAIN:   if (cfg_enable) state_nxt = RUN;
                     else if (all_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run_en      = (state == RUN);
        busy        = (state != IDLE) || !all_full;
        drained_set = (state == DRAIN) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit         <= {N{FULL}};
            rr_ptr         <= '0;
            inflight_total <= '0;
            drained        <= 1'b0;
        end else begin
            credit         <= credit_nxt;
            inflight_total <= IW'(N*CREDIT_DEPTH) - credit_sum;
            drained        <= drained_set;
            if (|fire) rr_ptr <= rr_ptr + 1'b1;
        end
    end

`ifdef BFLY_CREDIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_sticky <= 1'b0;
        else if (over_ret || ((|net_valid_vec) && !run_en))
            err_sticky <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_butterfly_credit_scheduler.sv
// Directed bench for butterfly_credit_scheduler (N=8, CREDIT_DEPTH=4) with hand-computed expectations.
module tb_butterfly_credit_scheduler;
    localparam int L = 3;
    localparam int N = 8;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           cfg_enable;
    logic [N-1:0]   up_valid_vec;
    logic [L*N-1:0] up_dst_vec;
    logic [W*N-1:0] up_payload_vec;
    logic [N-1:0]   up_ready_vec;
    logic [N-1:0]   net_valid_vec;
    logic [L*N-1:0] net_dst_vec;
    logic [W*N-1:0] net_payload_vec;
    logic [N-1:0]   net_ready_vec;
    logic [N-1:0]   ret_fire_vec;
    logic           busy;
    logic           drained;
    logic [5:0]     inflight_total;
`ifdef BFLY_CREDIT_CHECK_EN
    logic           err_sticky;
`endif

    int checks   = 0;
    int failures = 0;

    butterfly_credit_scheduler #(.NETWORK_WIDTH_LOG2(L), .W(W), .CREDIT_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_enable      (cfg_enable),
        .up_valid_vec    (up_valid_vec),
        .up_dst_vec      (up_dst_vec),
        .up_payload_vec  (up_payload_vec),
        .up_ready_vec    (up_ready_vec),
        .net_valid_vec   (net_valid_vec),
        .net_dst_vec     (net_dst_vec),
        .net_payload_vec (net_payload_vec),
        .net_ready_vec   (net_ready_vec),
        .ret_fire_vec    (ret_fire_vec),
        .busy            (busy),
        .drained         (drained),
        .inflight_total  (inflight_total)
`ifdef BFLY_CREDIT_CHECK_EN
        , .err_sticky    (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int lane, input int dst);
        up_valid_vec[lane]          = 1'b1;
        up_dst_vec[lane*L +: L]     = L'(dst);
        up_payload_vec[lane*W +: W] = 8'hA0 + 8'(lane);
    endtask

    initial begin
        logic [7:0] cont_exp [8];
        cont_exp = '{8'h80, 8'h80, 8'h01, 8'h10, 8'h10, 8'h10, 8'h10, 8'h80};
        rst = 1'b1; cfg_enable = 1'b0;
        up_valid_vec = '0; up_dst_vec = '0; up_payload_vec = '0;
        net_ready_vec = '1; ret_fire_vec = '0;

        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_drained", drained, 0);
        chk("rst_inflight", inflight_total, 0);
        chk("rst_net_valid", net_valid_vec, 0);
        chk("rst_up_ready", up_ready_vec, 0);
        rst = 1'b0;

        // basic grant: lane 2 -> dst 5, no grant while IDLE
        set_req(2, 5); #1;
        chk("idle_no_grant", net_valid_vec, 0);
        cfg_enable = 1'b1;
        tick();
        chk("basic_net_valid", net_valid_vec, 8'h04);
        chk("basic_up_ready", up_ready_vec, 8'h04);
        chk("basic_payload", net_payload_vec[23:16], 8'hA2);
        chk("basic_dst", net_dst_vec[8:6], 3'd5);
        tick();
        up_valid_vec = '0; #1;
        chk("basic_inflight_lag", inflight_total, 0);
        tick();
        chk("basic_inflight", inflight_total, 1);
        ret_fire_vec[5] = 1'b1;
        tick();
        ret_fire_vec = '0;
        chk("basic_ret_lag", inflight_total, 1);
        tick();
        chk("basic_ret", inflight_total, 0);

        // exhaustion on dst 3 (rr_ptr=1)
        set_req(0, 3); #1;
        for (int k = 0; k < 4; k++) begin
            chk("exh_fire", net_valid_vec, 8'h01);
            tick();
        end
        chk("exh_blocked_valid", net_valid_vec, 0);
        chk("exh_blocked_ready", up_ready_vec, 0);
        chk("exh_inflight3", inflight_total, 3);
        tick();
        chk("exh_still_blocked", net_valid_vec, 0);
        chk("exh_inflight4", inflight_total, 4);
        ret_fire_vec[3] = 1'b1; #1;
        chk("exh_ret_no_bypass", net_valid_vec, 0);
        tick();
        ret_fire_vec = '0; #1;
        chk("exh_regrant_valid", net_valid_vec, 8'h01);
        chk("exh_regrant_ready", up_ready_vec, 8'h01);
        tick();
        up_valid_vec = '0;
        ret_fire_vec[3] = 1'b1;
        tick(); tick(); tick(); tick();
        ret_fire_vec = '0;

        // contention on dst 1 from lanes 0,4,7; rr_ptr=6, immediate returns
        set_req(0, 1); set_req(4, 1); set_req(7, 1);
        ret_fire_vec[1] = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cont_grant%0d", k), net_valid_vec, cont_exp[k]);
            tick();
        end
        up_valid_vec = '0; ret_fire_vec = '0;
        tick();
        chk("cont_inflight", inflight_total, 0);

        // simultaneous take + return on dst 6 (rr_ptr=6)
        set_req(1, 6); #1;
        for (int k = 0; k < 4; k++) begin
            chk("tr_fill", net_valid_vec, 8'h02);
            tick();
        end
        chk("tr_wait", net_valid_vec, 0);
        ret_fire_vec[6] = 1'b1;
        tick();
        ret_fire_vec = '0; #1;
        chk("tr_grant_after_ret", net_valid_vec, 8'h02);
        ret_fire_vec[6] = 1'b1;
        tick();
        ret_fire_vec = '0; #1;
        chk("tr_credit_kept", net_valid_vec, 8'h02);
        tick();
        chk("tr_exhausted", net_valid_vec, 0);
        chk("tr_inflight_lag", inflight_total, 3);
        up_valid_vec = '0;
        tick();
        chk("tr_inflight", inflight_total, 4);

        // drain with 3 in flight on dst 6
        ret_fire_vec[6] = 1'b1;
        tick();
        ret_fire_vec = '0;
        cfg_enable = 1'b0;
        tick();
        set_req(0, 2); #1;
        chk("drain_no_valid", net_valid_vec, 0);
        chk("drain_no_ready", up_ready_vec, 0);
        chk("drain_busy0", busy, 1);
        ret_fire_vec[6] = 1'b1;
        tick();
        chk("drain_busy1", busy, 1);
        chk("drain_nopulse1", drained, 0);
        tick();
        chk("drain_busy2", busy, 1);
        tick();
        ret_fire_vec = '0; #1;
        chk("drain_busy3", busy, 1);
        chk("drain_nopulse3", drained, 0);
        tick();
        chk("drain_pulse", drained, 1);
        chk("drain_idle_busy", busy, 0);
        tick();
        chk("drain_pulse_end", drained, 0);
        chk("drain_inflight", inflight_total, 0);

        // reset mid-traffic (lane 0 -> dst 2 held)
        cfg_enable = 1'b1;
        tick();
        chk("rerun_grant", net_valid_vec, 8'h01);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_net_valid", net_valid_vec, 0);
        chk("midrst_up_ready", up_ready_vec, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_inflight", inflight_total, 0);
        rst = 1'b0;
        up_valid_vec = '0;
        tick(); tick();
        chk("postrst_inflight", inflight_total, 0);
        chk("postrst_busy_run", busy, 1);

`ifdef BFLY_CREDIT_CHECK_EN
        chk("err_clear", err_sticky, 0);
        ret_fire_vec[2] = 1'b1;
        tick();
        ret_fire_vec = '0;
        chk("err_set", err_sticky, 1);
        tick(); tick();
        chk("err_credit_sat", inflight_total, 0);
        chk("err_held", err_sticky, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
